// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory arbiter slice.
//   region_e : decoded target of a bus access (RAM, GPIO register, or unmapped)
//   mid_t    : master identifier (0 = CPU data port, 1 = loader/DMA port)
//   DEF_*    : default parameter values used by dmem_arbiter and rr_arb2
package dmem_pkg;

    localparam int REGION_W = 2;

    typedef enum logic [REGION_W-1:0] {
        REG_RAM  = 2'd0,
        REG_GPIO = 2'd1,
        REG_NONE = 2'd2
    } region_e;

    typedef logic mid_t;

    localparam int DEF_AW          = 32;
    localparam int DEF_DW          = 32;
    localparam int DEF_REGION_LSB  = 10;
    localparam int DEF_RAM_REGION  = 0;
    localparam int DEF_GPIO_REGION = 1;
    localparam int DEF_MAX_HOLD    = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with bounded bus lock.
//   clk, rst  : clock and asynchronous active-high reset
//   req_i[1:0]  : per-master request
//   lock_i[1:0] : per-master lock (only meaningful together with req)
//   gnt_o[1:0]  : one-hot grant, combinational, forced 0 during reset
//   winner_o    : id of the granted master (0 when nobody is granted)
// A locked owner keeps the bus across beats, but after MAX_HOLD consecutive
// locked beats with the other master waiting, the other master gets one beat.
module rr_arb2
    import dmem_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    output logic [1:0] gnt_o,
    output mid_t       winner_o
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    mid_t          last_winner_q, last_winner_d;
    mid_t          owner_q, owner_d;
    logic          lock_q, lock_d;
    logic [HW-1:0] hold_q, hold_d;

    logic lock_active;
    logic hold_full;
    logic accept;
    mid_t other;
    mid_t loser;

    // Grant selection
    always_comb begin
        gnt_o       = 2'b00;
        winner_o    = 1'b0;
        other       = ~owner_q;
        // The lock only holds while the owner still presents req and lock.
        lock_active = lock_q && req_i[owner_q] && lock_i[owner_q];
        hold_full   = (hold_q == HW'(MAX_HOLD));
        if (rst) begin
            gnt_o    = 2'b00;
            winner_o = 1'b0;
        end else if (lock_active) begin
            if (req_i[other] && hold_full) begin
                winner_o = other;
            end else begin
                winner_o = owner_q;
            end
            gnt_o[winner_o] = 1'b1;
        end else if (req_i[0] && req_i[1]) begin
            winner_o        = ~last_winner_q;
            gnt_o[winner_o] = 1'b1;
        end else if (req_i[0]) begin
            winner_o = 1'b0;
            gnt_o    = 2'b01;
        end else if (req_i[1]) begin
            winner_o = 1'b1;
            gnt_o    = 2'b10;
        end
    end

    // Next-state for round-robin pointer, lock ownership and hold counter
    always_comb begin
        accept        = |gnt_o;
        loser         = ~winner_o;
        last_winner_d = last_winner_q;
        owner_d       = owner_q;
        lock_d        = 1'b0;
        hold_d        = '0;
        if (accept) begin
            last_winner_d = winner_o;
            if (lock_i[winner_o]) begin
                lock_d  = 1'b1;
                owner_d = winner_o;
                if (lock_q && (owner_q == winner_o)) begin
                    // Continuing locked run: count beats the other side waited.
                    hold_d = hold_q;
                    if (req_i[loser] && !hold_full) begin
                        hold_d = hold_q + HW'(1);
                    end
                end else begin
                    // First beat of a new lock run already counts if someone waits.
                    hold_d = req_i[loser] ? HW'(1) : '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner_q <= 1'b1;
            owner_q       <= 1'b0;
            lock_q        <= 1'b0;
            hold_q        <= '0;
        end else begin
            last_winner_q <= last_winner_d;
            owner_q       <= owner_d;
            lock_q        <= lock_d;
            hold_q        <= hold_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter and address decoder for the data RAM and GPIO register.
//   clk, rst                 : clock, asynchronous active-high reset
//   mN_req_i/lock_i          : request / keep-grant from master N (0 = CPU, 1 = DMA)
//   mN_addr_i/wr_i/wdata_i   : byte address, byte enables (0 = read), write data
//   mN_gnt_o                 : access accepted this cycle (combinational)
//   mN_rvalid_o / mN_err_o   : read return one cycle after accept; err marks unmapped
//   m_rdata_o                : shared read data, qualified by mN_rvalid_o
//   ram_*                    : single-port synchronous RAM interface
//   gpio_*                   : GPIO register write strobe/data and current value
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int REGION_LSB  = DEF_REGION_LSB,
    parameter int RAM_REGION  = DEF_RAM_REGION,
    parameter int GPIO_REGION = DEF_GPIO_REGION,
    parameter int MAX_HOLD    = DEF_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req_i,
    input  logic          m0_lock_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [3:0]    m0_wr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic          m0_err_o,
    input  logic          m1_req_i,
    input  logic          m1_lock_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [3:0]    m1_wr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic          m1_err_o,
    output logic [DW-1:0] m_rdata_o,
    output logic          ram_en_o,
    output logic [3:0]    ram_wr_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic          gpio_we_o,
    output logic [7:0]    gpio_wdata_o,
    input  logic [7:0]    gpio_rdata_i
);

    localparam int RW = AW - REGION_LSB;
    localparam logic [RW-1:0] RAM_SEL  = RW'(RAM_REGION);
    localparam logic [RW-1:0] GPIO_SEL = RW'(GPIO_REGION);

    logic [1:0]    gnt;
    mid_t          winner;
    logic          accept;
    logic [AW-1:0] w_addr;
    logic [3:0]    w_wr;
    logic [DW-1:0] w_wdata;
    logic [RW-1:0] w_region_bits;
    region_e       w_region;
    logic          w_is_read;

    // Pending-return register: one outstanding read (or unmapped-write error)
    logic    rd_valid_q, rd_valid_d;
    logic    wr_err_q, wr_err_d;
    mid_t    mid_q, mid_d;
    region_e region_q, region_d;

    rr_arb2 #(
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({m1_req_i, m0_req_i}),
        .lock_i   ({m1_lock_i, m0_lock_i}),
        .gnt_o    (gnt),
        .winner_o (winner)
    );

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];
    assign accept   = |gnt;

    // Winner mux and region decode
    always_comb begin
        w_addr        = winner ? m1_addr_i  : m0_addr_i;
        w_wr          = winner ? m1_wr_i    : m0_wr_i;
        w_wdata       = winner ? m1_wdata_i : m0_wdata_i;
        w_region_bits = w_addr[AW-1:REGION_LSB];
        w_is_read     = (w_wr == 4'b0000);
        if (w_region_bits == RAM_SEL) begin
            w_region = REG_RAM;
        end else if (w_region_bits == GPIO_SEL) begin
            w_region = REG_GPIO;
        end else begin
            w_region = REG_NONE;
        end
    end

    // Slave strobes
    always_comb begin
        ram_en_o     = accept && (w_region == REG_RAM);
        ram_wr_o     = ram_en_o ? w_wr : 4'b0000;
        ram_addr_o   = w_addr;
        ram_wdata_o  = w_wdata;
        // GPIO is a single byte register; only lane 0 can write it.
        gpio_we_o    = accept && (w_region == REG_GPIO) && w_wr[0];
        gpio_wdata_o = w_wdata[7:0];
    end

    always_comb begin
        rd_valid_d = accept && w_is_read;
        wr_err_d   = accept && !w_is_read && (w_region == REG_NONE);
        mid_d      = winner;
        region_d   = w_region;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
            mid_q      <= 1'b0;
            region_q   <= REG_NONE;
        end else begin
            rd_valid_q <= rd_valid_d;
            wr_err_q   <= wr_err_d;
            mid_q      <= mid_d;
            region_q   <= region_d;
        end
    end

    // Return path
    always_comb begin
        m0_rvalid_o = rd_valid_q && (mid_q == 1'b0);
        m1_rvalid_o = rd_valid_q && (mid_q == 1'b1);
        m0_err_o    = (rd_valid_q || wr_err_q) && (region_q == REG_NONE) && (mid_q == 1'b0);
        m1_err_o    = (rd_valid_q || wr_err_q) && (region_q == REG_NONE) && (mid_q == 1'b1);
        m_rdata_o   = '0;
        if (rd_valid_q) begin
            case (region_q)
                REG_RAM:  m_rdata_o = ram_rdata_i;
                REG_GPIO: m_rdata_o = {{(DW-8){1'b0}}, gpio_rdata_i};
                default:  m_rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small synchronous RAM model
// and a GPIO register model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wr, m1_wr;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m_rdata;
    logic        ram_en;
    logic [3:0]  ram_wr;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        gpio_we;
    logic [7:0]  gpio_wdata;
    logic [7:0]  gpio_reg = 8'h00;

    logic [31:0] ram_mem [0:255];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req_i     (m0_req),
        .m0_lock_i    (m0_lock),
        .m0_addr_i    (m0_addr),
        .m0_wr_i      (m0_wr),
        .m0_wdata_i   (m0_wdata),
        .m0_gnt_o     (m0_gnt),
        .m0_rvalid_o  (m0_rvalid),
        .m0_err_o     (m0_err),
        .m1_req_i     (m1_req),
        .m1_lock_i    (m1_lock),
        .m1_addr_i    (m1_addr),
        .m1_wr_i      (m1_wr),
        .m1_wdata_i   (m1_wdata),
        .m1_gnt_o     (m1_gnt),
        .m1_rvalid_o  (m1_rvalid),
        .m1_err_o     (m1_err),
        .m_rdata_o    (m_rdata),
        .ram_en_o     (ram_en),
        .ram_wr_o     (ram_wr),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata),
        .gpio_we_o    (gpio_we),
        .gpio_wdata_o (gpio_wdata),
        .gpio_rdata_i (gpio_reg)
    );

    // Read-only synchronous RAM model; word index from address bits [9:2].
    always @(posedge clk) begin
        if (ram_en) ram_rdata <= ram_mem[ram_addr[9:2]];
    end

    always @(posedge clk) begin
        if (gpio_we) gpio_reg <= gpio_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_m0(input logic req, input logic lock, input logic [31:0] addr,
                            input logic [3:0] wr, input logic [31:0] wdata);
        m0_req = req; m0_lock = lock; m0_addr = addr; m0_wr = wr; m0_wdata = wdata;
    endtask

    task automatic drive_m1(input logic req, input logic lock, input logic [31:0] addr,
                            input logic [3:0] wr, input logic [31:0] wdata);
        m1_req = req; m1_lock = lock; m1_addr = addr; m1_wr = wr; m1_wdata = wdata;
    endtask

    task automatic idle_all();
        drive_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        int exp_w [4];
        int m1_count;
        int exp_g;

        exp_w = '{0, 1, 0, 1};
        for (int i = 0; i < 256; i++) ram_mem[i] = 32'hC0DE_0000 | i;

        // ---- Reset behaviour: request held during reset gets no grant
        rst = 1'b1;
        idle_all();
        drive_m0(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        settle();
        check_eq("rst_m0_gnt", m0_gnt, 0);
        check_eq("rst_ram_en", ram_en, 0);
        check_eq("rst_m0_rvalid", m0_rvalid, 0);
        check_eq("rst_gpio_we", gpio_we, 0);
        tick();
        rst = 1'b0;

        // ---- 1) m0 reads RAM 0x10
        settle();
        check_eq("t1_m0_gnt", m0_gnt, 1);
        check_eq("t1_m1_gnt", m1_gnt, 0);
        check_eq("t1_ram_en", ram_en, 1);
        check_eq("t1_ram_wr", ram_wr, 0);
        check_eq("t1_ram_addr", ram_addr, 32'h10);
        tick();
        idle_all();
        check_eq("t1_m0_rvalid", m0_rvalid, 1);
        check_eq("t1_m0_err", m0_err, 0);
        check_eq("t1_rdata", m_rdata, 32'hC0DE_0004);
        tick();
        check_eq("t1_rvalid_once", m0_rvalid, 0);

        // ---- 2) both request continuously, no lock, right after reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drive_m0(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        drive_m1(1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("t2_m0_gnt[%0d]", i), m0_gnt, (exp_w[i] == 0) ? 1 : 0);
            check_eq($sformatf("t2_m1_gnt[%0d]", i), m1_gnt, (exp_w[i] == 1) ? 1 : 0);
            tick();
            check_eq($sformatf("t2_m0_rvalid[%0d]", i), m0_rvalid, (exp_w[i] == 0) ? 1 : 0);
            check_eq($sformatf("t2_m1_rvalid[%0d]", i), m1_rvalid, (exp_w[i] == 1) ? 1 : 0);
            check_eq($sformatf("t2_rdata[%0d]", i), m_rdata,
                     (exp_w[i] == 0) ? 32'hC0DE_0004 : 32'hC0DE_0008);
        end

        // ---- 3) m1 locked while m0 waits: 16 m1 beats, one m0 beat, m1 resumes
        idle_all();
        drive_m0(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        settle();
        check_eq("t3_pre_m0_gnt", m0_gnt, 1);
        tick();
        drive_m1(1'b1, 1'b1, 32'h0000_0020, 4'h0, 32'h0);
        m1_count = 0;
        for (int i = 0; i < 18; i++) begin
            exp_g = (i == 16) ? 0 : 1;
            settle();
            check_eq($sformatf("t3_m1_gnt[%0d]", i), m1_gnt, (exp_g == 1) ? 1 : 0);
            check_eq($sformatf("t3_m0_gnt[%0d]", i), m0_gnt, (exp_g == 0) ? 1 : 0);
            if (i < 17 && m1_gnt) m1_count++;
            tick();
        end
        check_eq("t3_m1_run_len", m1_count, 16);

        // ---- 4) GPIO write and read-back
        idle_all();
        drive_m0(1'b1, 1'b0, 32'h0000_0400, 4'b0001, 32'h1234_56A5);
        settle();
        check_eq("t4_m0_gnt", m0_gnt, 1);
        check_eq("t4_gpio_we", gpio_we, 1);
        check_eq("t4_gpio_wdata", gpio_wdata, 32'hA5);
        check_eq("t4_ram_en", ram_en, 0);
        check_eq("t4_ram_wdata", ram_wdata, 32'h1234_56A5);
        tick();
        check_eq("t4_wr_rvalid", m0_rvalid, 0);
        check_eq("t4_wr_err", m0_err, 0);
        // Upper lanes only: GPIO must not be written.
        drive_m0(1'b1, 1'b0, 32'h0000_0400, 4'b1110, 32'h0000_00FF);
        settle();
        check_eq("t4_hi_lane_gpio_we", gpio_we, 0);
        check_eq("t4_hi_lane_ram_en", ram_en, 0);
        tick();
        drive_m0(1'b1, 1'b0, 32'h0000_0400, 4'b0000, 32'h0);
        tick();
        idle_all();
        check_eq("t4_rd_rvalid", m0_rvalid, 1);
        check_eq("t4_rd_data", m_rdata, 32'h0000_00A5);

        // ---- 5) unmapped accesses from m1
        drive_m1(1'b1, 1'b0, 32'h0001_0000, 4'b0000, 32'h0);
        settle();
        check_eq("t5_m1_gnt", m1_gnt, 1);
        check_eq("t5_ram_en", ram_en, 0);
        check_eq("t5_gpio_we", gpio_we, 0);
        tick();
        check_eq("t5_m1_rvalid", m1_rvalid, 1);
        check_eq("t5_m1_err", m1_err, 1);
        check_eq("t5_rdata", m_rdata, 0);
        check_eq("t5_m0_rvalid", m0_rvalid, 0);
        drive_m1(1'b1, 1'b0, 32'h0001_0000, 4'b1111, 32'hFFFF_FFFF);
        settle();
        check_eq("t5_wr_gpio_we", gpio_we, 0);
        tick();
        idle_all();
        check_eq("t5_wr_err", m1_err, 1);
        check_eq("t5_wr_rvalid", m1_rvalid, 0);
        tick();
        check_eq("t5_err_once", m1_err, 0);

        // ---- 6) reset right after a read accept drops the return
        drive_m0(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        settle();
        check_eq("t6_pre_m0_gnt", m0_gnt, 1);
        tick();
        rst = 1'b1;
        drive_m1(1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0);
        settle();
        check_eq("t6_rst_m0_rvalid", m0_rvalid, 0);
        check_eq("t6_rst_m0_gnt", m0_gnt, 0);
        check_eq("t6_rst_m1_gnt", m1_gnt, 0);
        tick();
        check_eq("t6_rst_m0_rvalid2", m0_rvalid, 0);
        tick();
        rst = 1'b0;
        settle();
        check_eq("t6_tie_m0_gnt", m0_gnt, 1);
        check_eq("t6_tie_m1_gnt", m1_gnt, 0);
        tick();
        idle_all();
        check_eq("t6_new_m0_rvalid", m0_rvalid, 1);
        check_eq("t6_new_m1_rvalid", m1_rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
